satd_block_accumulator: RTL

- Consumes the unsigned per-column partial absolute sums produced by the vertical-Hadamard/abs-sum stage, one beat per cycle, under a valid/ready handshake.
- Accumulates the WIDTH*HEIGHT/8 partials that make up one block, then presents the raw SATD and the normalised SATD under an output valid/ready handshake.
- Sits between the transform/abs-sum datapath and the mode-decision cost compare.

---
 rtl/satd_pkg.sv | 17 +
 rtl/satd_block_accumulator_if.sv | 25 ++
 rtl/satd_norm_round.sv | 21 ++
 rtl/satd_block_accumulator.sv | 81 ++++++++
 4 files changed

// File: rtl/satd_pkg.sv
// Shared constants and state type for the SATD accumulation path.
package satd_pkg;

   localparam int NORM_SHIFT_DEF = 2;

   typedef enum logic {ACCUM, HOLD} state_t;

   // Partials per block: the abs-sum stage folds eight samples into each partial.
   function automatic int npart_of(input int width, input int height);
      return (width * height) / 8;
   endfunction

   function automatic int acc_w(input int length, input int npart);
      return length + 8 + $clog2(npart);
   endfunction

endpackage

// File: rtl/satd_block_accumulator_if.sv
// Partial-sum input and block-result output handshakes of the SATD accumulator.
interface satd_block_accumulator_if #(
   parameter int LENGTH = 8,
   parameter int AW     = 19
);
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic [LENGTH+7:0] sum_partial;
   logic              out_valid;
   logic              out_ready;
   logic [AW-1:0]     satd_raw;
   logic [AW-1:0]     satd;
   logic              err_len;

   modport master (
      output in_valid, in_last, sum_partial, out_ready,
      input  in_ready, out_valid, satd_raw, satd, err_len
   );

   modport slave (
      input  in_valid, in_last, sum_partial, out_ready,
      output in_ready, out_valid, satd_raw, satd, err_len
   );
endinterface

// File: rtl/satd_norm_round.sv
// Combinational round-half-up right shift; the add is one bit wider so it cannot wrap.
module satd_norm_round #(
   parameter int AW    = 19,
   parameter int SHIFT = 2
) (
   input  logic [AW-1:0] x,
   output logic [AW-1:0] y
);
   generate
      if (SHIFT == 0) begin : g_pass
         assign y = x;
      end else begin : g_rnd
         localparam logic [AW:0] HALF = (AW+1)'(1) << (SHIFT - 1);
         logic [AW:0] biased;
         logic [AW:0] shifted;
         assign biased  = {1'b0, x} + HALF;
         assign shifted = biased >> SHIFT;
         assign y       = shifted[AW-1:0];
      end
   endgenerate
endmodule

// File: rtl/satd_block_accumulator.sv
// Sums the per-column partials of one block and hands raw and normalised SATD
// to the mode-decision stage under a valid/ready handshake.
module satd_block_accumulator
   import satd_pkg::*;
#(
   parameter int LENGTH     = 8,
   parameter int WIDTH      = 8,
   parameter int HEIGHT     = 8,
   parameter int NORM_SHIFT = NORM_SHIFT_DEF
) (
   input logic clk,
   input logic rst,
   satd_block_accumulator_if.slave bus
);
   localparam int NPART = npart_of(WIDTH, HEIGHT);
   localparam int CW    = $clog2(NPART);
   localparam int AW    = acc_w(LENGTH, NPART);

   state_t        state;
   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;
   logic          out_valid_q;
   logic [AW-1:0] satd_raw_q;
   logic [AW-1:0] satd_q;
   logic          err_len_q;

   logic          retire_ok;
   logic          accept;
   logic          last_cnt;
   logic          closing;
   logic [AW-1:0] sum_next;
   logic [AW-1:0] satd_next;

   // In HOLD a new beat may only enter on the cycle the held result retires.
   assign retire_ok = (state == ACCUM) || bus.out_ready;
   assign bus.in_ready = !rst && retire_ok;
   assign accept    = bus.in_valid && bus.in_ready;
   assign last_cnt  = (cnt == CW'(NPART - 1));
   assign closing   = last_cnt || bus.in_last;
   assign sum_next  = acc + AW'(bus.sum_partial);

   satd_norm_round #(.AW(AW), .SHIFT(NORM_SHIFT)) u_norm (
      .x (sum_next),
      .y (satd_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ACCUM;
         acc         <= '0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         satd_raw_q  <= '0;
         satd_q      <= '0;
         err_len_q   <= 1'b0;
      end else if (retire_ok) begin
         if (accept && closing) begin
            satd_raw_q  <= sum_next;
            satd_q      <= satd_next;
            err_len_q   <= bus.in_last != last_cnt;
            out_valid_q <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
            state       <= HOLD;
         end else begin
            out_valid_q <= 1'b0;
            state       <= ACCUM;
            if (accept) begin
               acc <= sum_next;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.satd_raw  = satd_raw_q;
   assign bus.satd      = satd_q;
   assign bus.err_len   = err_len_q;

endmodule
